// File: rtl/elevator_ctrl_n.sv
// Single-car SCAN elevator controller: latches floor requests, keeps direction while work lies
// ahead, times travel and door dwell from an external tick.
module elevator_ctrl_n #(
  parameter int FLOORS     = 8,
  parameter int FLOOR_W    = 3,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 4,
  parameter int CNT_W      = 4
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic               tick,
  input  logic [FLOORS-1:0]  req_set,
  input  logic               door_hold,
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending,
  output logic [CNT_W-1:0]   door_cnt
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t             state, state_nxt;
  logic [FLOOR_W-1:0] floor_nxt;
  logic               dir_nxt;
  logic [FLOORS-1:0]  pending_nxt, clr, here;
  logic [CNT_W-1:0]   door_cnt_nxt, move_cnt, move_cnt_nxt;
  logic               above, below, hit, reload;

  // Split pending requests around the current floor.
  always_comb begin
    here  = '0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FLOOR_W'(i) == floor)     here[i] = 1'b1;
      else if (FLOOR_W'(i) > floor) above   = above | pending[i];
      else                          below   = below | pending[i];
    end
  end

  assign hit    = |(here & (pending | req_set));
  assign reload = door_hold | (|(here & req_set));

  always_comb begin
    state_nxt    = state;
    floor_nxt    = floor;
    dir_nxt      = dir_up;
    door_cnt_nxt = door_cnt;
    move_cnt_nxt = move_cnt;
    clr          = '0;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_nxt    = DOOR;
          clr          = here;
          door_cnt_nxt = CNT_W'(DOOR_TICKS);
        end else if (above && (dir_up || !below)) begin
          state_nxt    = MOVE;
          dir_nxt      = 1'b1;
          move_cnt_nxt = CNT_W'(MOVE_TICKS);
        end else if (below) begin
          state_nxt    = MOVE;
          dir_nxt      = 1'b0;
          move_cnt_nxt = CNT_W'(MOVE_TICKS);
        end
      end
      MOVE: begin
        if (tick) begin
          if (move_cnt == CNT_W'(1)) begin
            move_cnt_nxt = '0;
            floor_nxt    = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
            state_nxt    = IDLE;
          end else begin
            move_cnt_nxt = move_cnt - CNT_W'(1);
          end
        end
      end
      DOOR: begin
        // The car is standing here, so a repeated request is absorbed rather than latched.
        clr = here;
        if (reload) begin
          door_cnt_nxt = CNT_W'(DOOR_TICKS);
        end else if (tick) begin
          if (door_cnt == CNT_W'(1)) begin
            door_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            door_cnt_nxt = door_cnt - CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending | req_set) & ~clr;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state     <= IDLE;
      floor     <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      door_cnt  <= '0;
      move_cnt  <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state     <= state_nxt;
      floor     <= floor_nxt;
      dir_up    <= dir_nxt;
      pending   <= pending_nxt;
      door_cnt  <= door_cnt_nxt;
      move_cnt  <= move_cnt_nxt;
      moving    <= (state_nxt == MOVE);
      door_open <= (state_nxt == DOOR);
    end
  end

endmodule
